dpram_fifo_ctrl: RTL
====================

# dpram_fifo_ctrl

Pointer and flag controller that turns the team's two-port RAM (one registered-address read port, one write port) into a synchronous FIFO. The block owns the write and read address pointers, the RAM write-enable and the full/empty bookkeeping, and drives the RAM's write and read ports directly. It sits between a producer and a consumer that use request-style handshakes. At the top level it is paired with a DualPortRAM instance of matching widths.

## Interface
- Data_Width, 8, width of one FIFO entry.
- Addr_Width, 2, RAM address width; FIFO depth = 2**Addr_Width.

- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_req  in  1  producer push request.
- wr_data  in  Data_Width  push data.
- rd_req  in  1  consumer pop request.
- rd_data  out  Data_Width  popped data; valid when rd_valid=1.
- rd_valid  out  1  registered pulse, one cycle after an accepted pop.
- full  out  1  count == 2**Addr_Width.
- empty  out  1  count == 0.
- count  out  Addr_Width+1  occupied entries.
- ram_wr_ena  out  1  to RAM write enable.
- ram_wr_addr  out  Addr_Width  to RAM write address.
- ram_data_write  out  Data_Width  to RAM write data.
- ram_re_addr  out  Addr_Width  to RAM read address (RAM registers it).
- ram_data_read  in  Data_Width  from RAM read data.
- overflow, underflow  out  1 each  sticky error flags (only with the configuration macro).

## Operation
- Pointers wptr, rptr: Addr_Width+1 bits each, reset to 0. Low bits address the RAM; the MSB is the wrap bit.
- full = (wptr MSB != rptr MSB) and (low bits equal). empty = (wptr == rptr). count = wptr - rptr, modulo 2**(Addr_Width+1).
- Push accepted: wr_acc = wr_req & ~full.
  - ram_wr_ena = wr_acc (combinational); ram_wr_addr = wptr low bits; ram_data_write = wr_data.
  - wptr increments at the edge.
- Pop accepted: rd_acc = rd_req & ~empty.
  - ram_re_addr = rptr low bits, driven every cycle regardless of rd_req.
  - rptr increments at the edge; rd_valid <= rd_acc.
- rd_data = ram_data_read, passed straight through. In the cycle after a pop, the RAM's address register still holds the popped address, so the output is the popped entry.
- Flags are evaluated on pre-edge state only; there is no bypass:
  - Push while full is refused, even if a pop is accepted in the same cycle.
  - Pop while empty is refused, even if a push is accepted in the same cycle.
- Simultaneous accepted push and pop: both pointers advance; count unchanged.
- Read/write collision is impossible: pops read only occupied slots and pushes write only free slots.
- Wrap-around: pointer low bits roll from 2**Addr_Width-1 to 0 and the MSB toggles.

## Timing
- Reset values: rd_valid=0, full=0, empty=1, count=0, ram_wr_ena=0, ram_wr_addr=0, ram_re_addr=0, overflow=0, underflow=0.
- Reset asserted mid-operation: pointers clear asynchronously and the FIFO becomes logically empty. RAM contents are not cleared. Any rd_valid in flight is dropped.
- Push latency: an entry accepted at edge N is poppable at edge N+1 (empty deasserts after edge N).
- Pop latency: rd_acc at edge N gives rd_valid=1 and valid rd_data during cycle N+1. Back-to-back pops deliver one entry per cycle.
- full, empty and count are registered-state derived and change only at clock edges.

## Configuration
- FIFO_ERR_FLAGS_EN defined:
  - overflow sets on wr_req & full; underflow sets on rd_req & empty.
  - Both flags are sticky until reset and are ports of the block.
- FIFO_ERR_FLAGS_EN undefined: both ports and their logic are absent. Refused requests are silently ignored.

## Structure
- Shared package dpram_fifo_pkg: pointer width constant Addr_Width+1, depth constant 2**Addr_Width, and the default Data_Width and Addr_Width values.
- No sub-module inside. The wrapper dpram_fifo instantiates dpram_fifo_ctrl plus DualPortRAM with identical parameters.

## Test plan
All scenarios use Data_Width=8, Addr_Width=2.
- Reset, then idle → empty=1, full=0, count=0, rd_valid=0, ram_wr_ena=0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles → full=1, count=4. A 5th push of 0x55 is refused, ram_wr_ena=0, overflow=1 if enabled.
- Four consecutive pops from full → rd_valid high for 4 cycles with rd_data 0x11, 0x22, 0x33, 0x44, then empty=1. An extra pop gives no rd_valid and underflow=1 if enabled.
- Push and pop every cycle for 10 cycles starting from count=2 → count stays 2; output order equals input order across pointer wrap.
- Push and pop in the same cycle while empty → only the push is accepted, count=1, no rd_valid. Push and pop while full → only the pop is accepted, count=3.
- Assert reset with count=3 → count=0, empty=1 immediately; a new push of 0xA5 then pop returns 0xA5.

Source files
------------

// File: rtl/dpram_fifo_pkg.sv
// dpram_fifo_pkg
// Shared constants for the DualPortRAM-backed FIFO: default entry and
// address widths, and the pointer width / depth derived from them.
// Pointers carry one extra wrap bit above the RAM address.
package dpram_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 2;
  localparam int PTR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;
  localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;

endpackage

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
// Pointer and flag controller that turns a two-port RAM (registered read
// address, plain write port) into a synchronous FIFO.
//
// Configuration macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// outputs; without it refused requests are silently ignored.
//
// Ports
//   clk, reset            clock, async active-high reset
//   wr_req, wr_data       producer push request / data
//   rd_req                consumer pop request
//   rd_data, rd_valid     popped data, valid one cycle after an accepted pop
//   full, empty, count    occupancy, derived from registered pointers only
//   ram_wr_ena/addr/data  RAM write port
//   ram_re_addr           RAM read address (RAM registers it)
//   ram_data_read         RAM read data
//   overflow, underflow   sticky error flags (FIFO_ERR_FLAGS_EN only)
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF,
  parameter int Addr_Width = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [Data_Width-1:0] wr_data,
  input  logic                  rd_req,
  output logic [Data_Width-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [Addr_Width:0]   count,
  output logic                  ram_wr_ena,
  output logic [Addr_Width-1:0] ram_wr_addr,
  output logic [Data_Width-1:0] ram_data_write,
  output logic [Addr_Width-1:0] ram_re_addr,
  input  logic [Data_Width-1:0] ram_data_read
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int PtrW = Addr_Width + 1;
  localparam logic [PtrW-1:0] PtrOne = {{(PtrW-1){1'b0}}, 1'b1};

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic            rd_valid_q;
  logic            wr_acc, rd_acc;

  // Flags come from pre-edge pointer state only; a same-cycle pop never
  // frees room for a push, and a same-cycle push never feeds a pop.
  assign full  = (wptr_q[Addr_Width] != rptr_q[Addr_Width]) &&
                 (wptr_q[Addr_Width-1:0] == rptr_q[Addr_Width-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign count = wptr_q - rptr_q;

  assign wr_acc = wr_req & ~full;
  assign rd_acc = rd_req & ~empty;

  assign wptr_d = wr_acc ? (wptr_q + PtrOne) : wptr_q;
  assign rptr_d = rd_acc ? (rptr_q + PtrOne) : rptr_q;

  assign ram_wr_ena     = wr_acc;
  assign ram_wr_addr    = wptr_q[Addr_Width-1:0];
  assign ram_data_write = wr_data;
  // Presented every cycle: the RAM latches it at the pop edge, so the
  // popped entry appears on ram_data_read in the following cycle.
  assign ram_re_addr    = rptr_q[Addr_Width-1:0];

  assign rd_data  = ram_data_read;
  assign rd_valid = rd_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_acc;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  | (wr_req & full);
      underflow_q <= underflow_q | (rd_req & empty);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
